// File: rtl/simd_product_accumulator_if.sv
// Handshake bundle between the chopped multiplier, the product accumulator and its consumer.
interface simd_product_accumulator_if #(
    parameter int IN_WIDTH  = 24,
    parameter int ACC_WIDTH = 48
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_signed;
    logic                 HALF_1;
    logic                 in_first;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [1:0]           overflow;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_signed, HALF_1, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, overflow
    );

    // Accumulator side.
    modport slave (
        input  in_valid, in_data, in_signed, HALF_1, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, overflow
    );
endinterface

// File: rtl/simd_product_accumulator.sv
// Two-stage product accumulator: S1 extends the product per mode, S2 accumulates
// (whole word or two carry-isolated lanes), then a result register holds each
// completed group together with its sticky overflow flags.
module simd_product_accumulator #(
    parameter int IN_WIDTH  = 24,
    parameter int ACC_WIDTH = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    simd_product_accumulator_if.slave  bus
);
    localparam int LANE_IN  = IN_WIDTH / 2;
    localparam int LANE_ACC = ACC_WIDTH / 2;

    typedef logic [ACC_WIDTH-1:0] acc_t;

    // Full mode extends the whole product; lane mode extends each half on its own.
    function automatic acc_t extend(input logic [IN_WIDTH-1:0] d, input logic sgn, input logic half);
        acc_t              r;
        logic [LANE_IN-1:0] l0;
        logic [LANE_IN-1:0] l1;
        l0 = d[LANE_IN-1:0];
        l1 = d[IN_WIDTH-1:LANE_IN];
        if (half) begin
            r = {{(LANE_ACC-LANE_IN){sgn & l1[LANE_IN-1]}}, l1,
                 {(LANE_ACC-LANE_IN){sgn & l0[LANE_IN-1]}}, l0};
        end else begin
            r = {{(ACC_WIDTH-IN_WIDTH){sgn & d[IN_WIDTH-1]}}, d};
        end
        return r;
    endfunction

    logic       mode_q, mode_d;
    logic       s1_valid_q, s1_valid_d;
    acc_t       s1_op_q, s1_op_d;
    logic       s1_first_q, s1_first_d;
    logic       s1_last_q, s1_last_d;
    logic       s1_half_q, s1_half_d;
    logic       s1_signed_q, s1_signed_d;
    acc_t       acc_q, acc_d;
    logic [1:0] ovf_q, ovf_d;
    logic       s2_done_q, s2_done_d;
    logic       out_valid_q, out_valid_d;
    acc_t       out_data_q, out_data_d;
    logic [1:0] overflow_q, overflow_d;

    logic                stall;
    logic                mode_eff;
    logic                restart;
    acc_t                base;
    logic [1:0]          ovf_base;
    logic [ACC_WIDTH:0]  sum_full;
    logic [LANE_ACC:0]   sum_lo;
    logic [LANE_ACC:0]   sum_hi;
    acc_t                sum;
    logic [1:0]          ovf_new;
    logic                ovf_lo;
    logic                ovf_hi;
    logic                ovf_f;

    // Adder: a group opener or the beat right after a closed group starts from zero.
    always_comb begin
        restart  = s1_first_q | s2_done_q;
        base     = restart ? '0 : acc_q;
        ovf_base = restart ? 2'b00 : ovf_q;
        sum_full = {1'b0, base} + {1'b0, s1_op_q};
        sum_lo   = {1'b0, base[LANE_ACC-1:0]} + {1'b0, s1_op_q[LANE_ACC-1:0]};
        sum_hi   = {1'b0, base[ACC_WIDTH-1:LANE_ACC]} + {1'b0, s1_op_q[ACC_WIDTH-1:LANE_ACC]};
        ovf_lo   = 1'b0;
        ovf_hi   = 1'b0;
        ovf_f    = 1'b0;
        if (s1_half_q) begin
            sum = {sum_hi[LANE_ACC-1:0], sum_lo[LANE_ACC-1:0]};
            if (s1_signed_q) begin
                ovf_lo = (s1_op_q[LANE_ACC-1] == base[LANE_ACC-1]) &&
                         (sum_lo[LANE_ACC-1] != s1_op_q[LANE_ACC-1]);
                ovf_hi = (s1_op_q[ACC_WIDTH-1] == base[ACC_WIDTH-1]) &&
                         (sum_hi[LANE_ACC-1] != s1_op_q[ACC_WIDTH-1]);
            end else begin
                ovf_lo = sum_lo[LANE_ACC];
                ovf_hi = sum_hi[LANE_ACC];
            end
            ovf_new = ovf_base | {ovf_hi, ovf_lo};
        end else begin
            sum = sum_full[ACC_WIDTH-1:0];
            if (s1_signed_q) begin
                ovf_f = (s1_op_q[ACC_WIDTH-1] == base[ACC_WIDTH-1]) &&
                        (sum_full[ACC_WIDTH-1] != s1_op_q[ACC_WIDTH-1]);
            end else begin
                ovf_f = sum_full[ACC_WIDTH];
            end
            ovf_new = ovf_base | {1'b0, ovf_f};
        end
    end

    // Next state: the pipe only freezes when a finished group cannot enter a full output register.
    always_comb begin
        mode_d      = mode_q;
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_first_d  = s1_first_q;
        s1_last_d   = s1_last_q;
        s1_half_d   = s1_half_q;
        s1_signed_d = s1_signed_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        s2_done_d   = s2_done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overflow_d  = overflow_q;

        stall    = out_valid_q & ~bus.out_ready & s2_done_q;
        mode_eff = bus.in_first ? bus.HALF_1 : mode_q;

        if (!stall) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d     = extend(bus.in_data, bus.in_signed, mode_eff);
                s1_first_d  = bus.in_first;
                s1_last_d   = bus.in_last;
                s1_half_d   = mode_eff;
                s1_signed_d = bus.in_signed;
                mode_d      = mode_eff;
            end

            s2_done_d = s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                acc_d = sum;
                ovf_d = ovf_new;
            end else if (s2_done_q) begin
                acc_d = '0;
                ovf_d = 2'b00;
            end

            if (s2_done_q) begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
                overflow_d  = ovf_q;
            end else if (bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_half_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 2'b00;
            s2_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 2'b00;
        end else begin
            mode_q      <= mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_half_q   <= s1_half_d;
            s1_signed_q <= s1_signed_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            s2_done_q   <= s2_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_simd_product_accumulator.sv
module tb_simd_product_accumulator;
    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    simd_product_accumulator_if #(.IN_WIDTH(24), .ACC_WIDTH(48)) bus0 ();
    simd_product_accumulator_if #(.IN_WIDTH(24), .ACC_WIDTH(26)) bus1 ();

    simd_product_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(48)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    simd_product_accumulator #(.IN_WIDTH(24), .ACC_WIDTH(26)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [47:0] q0_data[$];
    logic [1:0]  q0_ovf[$];
    logic [25:0] q1_data[$];
    logic [1:0]  q1_ovf[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [23:0] d, input logic sgn,
                         input logic half, input logic first, input logic last);
        if (sel == 0) begin
            bus0.in_valid = v; bus0.in_data = d; bus0.in_signed = sgn;
            bus0.HALF_1 = half; bus0.in_first = first; bus0.in_last = last;
        end else begin
            bus1.in_valid = v; bus1.in_data = d; bus1.in_signed = sgn;
            bus1.HALF_1 = half; bus1.in_first = first; bus1.in_last = last;
        end
    endtask

    task automatic beat(input int sel, input logic [23:0] d, input logic sgn,
                        input logic half, input logic first, input logic last);
        logic took;
        int   budget;
        took   = 1'b0;
        budget = 0;
        drive(sel, 1'b1, d, sgn, half, first, last);
        while (!took) begin
            @(negedge clk);
            took = (sel == 0) ? bus0.in_ready : bus1.in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!took && budget > 50) begin
                tests++;
                fails++;
                $display("FAIL beat_accept: dut%0d in_ready stuck at 0, expected 1", sel);
                break;
            end
        end
        drive(sel, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input int sel, input logic [47:0] d, input logic [1:0] o);
        if (sel == 0) begin
            q0_data.push_back(d);
            q0_ovf.push_back(o);
        end else begin
            q1_data.push_back(d[25:0]);
            q1_ovf.push_back(o);
        end
    endtask

    // Scoreboard monitor, wide instance.
    always @(negedge clk) begin
        if (!reset && bus0.out_valid && bus0.out_ready) begin
            tests++;
            if (q0_data.size() == 0) begin
                fails++;
                $display("FAIL out0_unexpected: got data %h ovf %b, expected no result", bus0.out_data, bus0.overflow);
            end else begin
                logic [47:0] ed;
                logic [1:0]  eo;
                ed = q0_data.pop_front();
                eo = q0_ovf.pop_front();
                if (bus0.out_data !== ed || bus0.overflow !== eo) begin
                    fails++;
                    $display("FAIL out0_result: got data %h ovf %b, expected data %h ovf %b",
                             bus0.out_data, bus0.overflow, ed, eo);
                end
            end
        end
    end

    // Scoreboard monitor, narrow (26-bit) instance.
    always @(negedge clk) begin
        if (!reset && bus1.out_valid && bus1.out_ready) begin
            tests++;
            if (q1_data.size() == 0) begin
                fails++;
                $display("FAIL out1_unexpected: got data %h ovf %b, expected no result", bus1.out_data, bus1.overflow);
            end else begin
                logic [25:0] ed;
                logic [1:0]  eo;
                ed = q1_data.pop_front();
                eo = q1_ovf.pop_front();
                if (bus1.out_data !== ed || bus1.overflow !== eo) begin
                    fails++;
                    $display("FAIL out1_result: got data %h ovf %b, expected data %h ovf %b",
                             bus1.out_data, bus1.overflow, ed, eo);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        drive(0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {63'd0, bus0.out_valid}, 64'd0);
        chk("rst_out_data", {16'd0, bus0.out_data}, 64'd0);
        chk("rst_overflow", {62'd0, bus0.overflow}, 64'd0);
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, bus0.in_ready}, 64'd1);
        sync();

        // Full mode signed: 0x10 + (-16) + 5, plus latency of the closing beat
        beat(0, 24'h000010, 1'b1, 1'b0, 1'b1, 1'b0);
        beat(0, 24'hFFFFF0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(0, 48'h000000000005, 2'b00);
        beat(0, 24'h000005, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t1_latency_early", {63'd0, bus0.out_valid}, 64'd0);
        @(negedge clk);
        chk("t1_latency", {63'd0, bus0.out_valid}, 64'd1);
        sync();

        // Lane mode unsigned, no carry leak; HALF_1 toggles on non-first beats are ignored
        beat(0, 24'hFFF001, 1'b0, 1'b1, 1'b1, 1'b0);
        beat(0, 24'hFFF001, 1'b0, 1'b0, 1'b0, 1'b0);
        push(0, 48'h002FFD000003, 2'b00);
        beat(0, 24'hFFF001, 1'b0, 1'b0, 1'b0, 1'b1);

        // Lane mode signed, then an immediate beat without in_first: restarts at zero in lane mode
        beat(0, 24'hFFF001, 1'b1, 1'b1, 1'b1, 1'b0);
        push(0, 48'hFFFFFE000002, 2'b00);
        beat(0, 24'hFFF001, 1'b1, 1'b1, 1'b0, 1'b1);
        push(0, 48'hFFFFFF000001, 2'b00);
        beat(0, 24'hFFF001, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) sync();

        // 26-bit accumulator: lane0 signed overflow, then cleared by the next group
        beat(1, 24'h0007FF, 1'b1, 1'b1, 1'b1, 1'b0);
        beat(1, 24'h0007FF, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1, 48'h00000017FD, 2'b01);
        beat(1, 24'h0007FF, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) sync();
        @(negedge clk);
        chk("t4_ovf_holds", {62'd0, bus1.overflow}, 64'd1);
        sync();
        push(1, 48'h0000000001, 2'b00);
        beat(1, 24'h000001, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (4) sync();

        // Backpressure: second group completes while the first result is unread
        bus0.out_ready = 1'b0;
        push(0, 48'h000000000011, 2'b00);
        beat(0, 24'h000011, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) sync();
        @(negedge clk);
        chk("t5_first_held_valid", {63'd0, bus0.out_valid}, 64'd1);
        chk("t5_first_held_data", {16'd0, bus0.out_data}, 64'h11);
        sync();
        push(0, 48'h000000000022, 2'b00);
        beat(0, 24'h000022, 1'b0, 1'b0, 1'b1, 1'b1);
        sync();
        @(negedge clk);
        chk("t5_in_ready_low", {63'd0, bus0.in_ready}, 64'd0);
        chk("t5_stall_data", {16'd0, bus0.out_data}, 64'h11);
        sync();
        @(negedge clk);
        chk("t5_stall_data_2", {16'd0, bus0.out_data}, 64'h11);
        sync();
        bus0.out_ready = 1'b1;
        sync();
        bus0.out_ready = 1'b0;
        @(negedge clk);
        chk("t5_second_valid", {63'd0, bus0.out_valid}, 64'd1);
        chk("t5_second_data", {16'd0, bus0.out_data}, 64'h22);
        chk("t5_in_ready_back", {63'd0, bus0.in_ready}, 64'd1);
        sync();
        bus0.out_ready = 1'b1;
        repeat (2) sync();

        // Reset in the middle of a group discards it
        beat(0, 24'h000100, 1'b0, 1'b0, 1'b1, 1'b0);
        beat(0, 24'h000200, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_valid", {63'd0, bus0.out_valid}, 64'd0);
        chk("t6_rst_data", {16'd0, bus0.out_data}, 64'd0);
        chk("t6_rst_ovf1", {62'd0, bus1.overflow}, 64'd0);
        sync();
        reset = 1'b0;
        sync();
        push(0, 48'h000000000007, 2'b00);
        beat(0, 24'h000007, 1'b1, 1'b0, 1'b1, 1'b1);

        // Drain the scoreboards with a bounded wait
        for (int i = 0; i < 100; i++) begin
            if (q0_data.size() == 0 && q1_data.size() == 0) break;
            sync();
        end
        chk("drain_q0", 64'(q0_data.size()), 64'd0);
        chk("drain_q1", 64'(q1_data.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
